// File: rtl/render_pkg.sv
// render_pkg: shared dispatcher state encoding and area-width helper
//   dispatch_state_t : dispatcher FSM states
//   area_width(vw)   : width of an exact signed twice-area for vw-bit coords
package render_pkg;

   typedef enum logic [2:0] {IDLE, AREA, CULL, LAUNCH, WAIT, FINISH} dispatch_state_t;

   function automatic int area_width(input int vw);
      return 2 * vw + 2;
   endfunction

endpackage

// File: rtl/triangle_area2.sv
// triangle_area2: combinational signed twice-area of a screen-space triangle
//   x0,y0..x2,y2 : signed VW-bit vertex coordinates
//   a2           : (x1-x0)*(y2-y0)-(x2-x0)*(y1-y0), positive for CCW
module triangle_area2
   import render_pkg::*;
#(
   parameter int VW = 12
) (
   input  logic signed [VW-1:0]                x0,
   input  logic signed [VW-1:0]                y0,
   input  logic signed [VW-1:0]                x1,
   input  logic signed [VW-1:0]                y1,
   input  logic signed [VW-1:0]                x2,
   input  logic signed [VW-1:0]                y2,
   output logic signed [area_width(VW)-1:0]    a2
);

   localparam int AW = area_width(VW);

   // everything is widened before subtracting so the result is exact
   logic signed [AW-1:0] dx1, dy1, dx2, dy2;

   assign dx1 = AW'(x1) - AW'(x0);
   assign dy1 = AW'(y1) - AW'(y0);
   assign dx2 = AW'(x2) - AW'(x0);
   assign dy2 = AW'(y2) - AW'(y0);
   assign a2  = dx1 * dy2 - dx2 * dy1;

endmodule

// File: rtl/triangle_dispatcher.sv
// triangle_dispatcher: culls/fixes winding of triangles and sequences the rasterizer
//   tri_valid/tri_ready/tri_last, x0..y2 : triangle input port
//   rast_x0..rast_y2, rast_rst, rast_done : rasterizer interface
//   busy, frame_done, timeout_err         : status
//   tri_count, cull_count                 : per-frame saturating counters
module triangle_dispatcher
   import render_pkg::*;
#(
   parameter int VERTEX_WIDTH   = 12,
   parameter int COUNT_WIDTH    = 16,
   parameter int CULL_BACKFACE  = 1,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tri_valid,
   output logic                           tri_ready,
   input  logic                           tri_last,
   input  logic signed [VERTEX_WIDTH-1:0] x0,
   input  logic signed [VERTEX_WIDTH-1:0] y0,
   input  logic signed [VERTEX_WIDTH-1:0] x1,
   input  logic signed [VERTEX_WIDTH-1:0] y1,
   input  logic signed [VERTEX_WIDTH-1:0] x2,
   input  logic signed [VERTEX_WIDTH-1:0] y2,
   output logic signed [VERTEX_WIDTH-1:0] rast_x0,
   output logic signed [VERTEX_WIDTH-1:0] rast_y0,
   output logic signed [VERTEX_WIDTH-1:0] rast_x1,
   output logic signed [VERTEX_WIDTH-1:0] rast_y1,
   output logic signed [VERTEX_WIDTH-1:0] rast_x2,
   output logic signed [VERTEX_WIDTH-1:0] rast_y2,
   output logic                           rast_rst,
   input  logic                           rast_done,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           timeout_err,
   output logic [COUNT_WIDTH-1:0]         tri_count,
   output logic [COUNT_WIDTH-1:0]         cull_count
);

   localparam int AW = area_width(VERTEX_WIDTH);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

   dispatch_state_t state, state_nxt;
   logic signed [AW-1:0] area_c, a2;
   logic [WW-1:0] wd;
   logic last, new_frame, accept, done_ok, expire, cull, swap;

   // the latched coordinates double as the rasterizer outputs; area is taken from them
   triangle_area2 #(.VW(VERTEX_WIDTH)) u_area (
      .x0(rast_x0), .y0(rast_y0), .x1(rast_x1), .y1(rast_y1), .x2(rast_x2), .y2(rast_y2),
      .a2(area_c)
   );

   // wd==0 marks the first WAIT cycle, where a stale done from the previous run is ignored
   assign done_ok = state == WAIT && wd != '0 && rast_done;
   assign expire  = state == WAIT && wd == WD_MAX;
   assign cull    = state == CULL && state_nxt == FINISH;
   assign swap    = state == CULL && state_nxt == LAUNCH && a2 < 0;

   always_comb begin
      state_nxt  = state;
      tri_ready  = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            tri_ready = 1'b1;
            busy      = 1'b0;
            accept    = tri_valid;
            state_nxt = tri_valid ? AREA : IDLE;
         end
         AREA:    state_nxt = CULL;
         CULL:    state_nxt = (a2 > 0 || (a2 < 0 && CULL_BACKFACE == 0)) ? LAUNCH : FINISH;
         LAUNCH:  state_nxt = WAIT;
         WAIT:    state_nxt = (done_ok || expire) ? FINISH : WAIT;
         FINISH: begin
            frame_done = last;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rast_x0     <= '0;
         rast_y0     <= '0;
         rast_x1     <= '0;
         rast_y1     <= '0;
         rast_x2     <= '0;
         rast_y2     <= '0;
         a2          <= '0;
         wd          <= '0;
         last        <= 1'b0;
         new_frame   <= 1'b1;
         rast_rst    <= 1'b1;
         timeout_err <= 1'b0;
         tri_count   <= '0;
         cull_count  <= '0;
      end else begin
         state    <= state_nxt;
         // registered so the pulse lines up with LAUNCH, or with FINISH after a watchdog abort
         rast_rst <= state_nxt == LAUNCH || (expire && !done_ok);
         wd       <= state == WAIT ? wd + 1'b1 : '0;
         if (accept) begin
            rast_x0   <= x0;
            rast_y0   <= y0;
            rast_x1   <= x1;
            rast_y1   <= y1;
            rast_x2   <= x2;
            rast_y2   <= y2;
            last      <= tri_last;
            new_frame <= 1'b0;
            if (new_frame) begin
               tri_count  <= '0;
               cull_count <= '0;
            end
         end
         if (state == AREA) a2 <= area_c;
         if (swap) begin
            rast_x1 <= rast_x2;
            rast_y1 <= rast_y2;
            rast_x2 <= rast_x1;
            rast_y2 <= rast_y1;
         end
         if (cull && cull_count != CMAX) cull_count <= cull_count + 1'b1;
         if (done_ok && tri_count != CMAX) tri_count <= tri_count + 1'b1;
         if (expire && !done_ok) timeout_err <= 1'b1;
         if (state == FINISH && last) new_frame <= 1'b1;
      end
   end

endmodule
